mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data > fetch (> debug), one outstanding transaction, bounded timeout.
// Optional debug reader port enabled by defining MEM_ARB_DEBUG_PORT_EN.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [23:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    input  logic        f_req,
    input  logic [23:0] f_addr,
    output logic        f_done,
`ifdef MEM_ARB_DEBUG_PORT_EN
    input  logic        g_req,
    input  logic [23:0] g_addr,
    output logic        g_done,
`endif
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

`ifdef MEM_ARB_DEBUG_PORT_EN
    localparam int OW = 2;
`else
    localparam int OW = 1;
`endif
    localparam logic [OW-1:0] OWN_D = '0;
    localparam logic [OW-1:0] OWN_F = OW'(1);
`ifdef MEM_ARB_DEBUG_PORT_EN
    localparam logic [OW-1:0] OWN_G = OW'(2);
`endif

    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic          we_q, we_d;
    logic [23:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else if (f_req) begin
                    owner_d = OWN_F;
                    we_d    = 1'b0;
                    addr_d  = f_addr;
                    wdata_d = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
`ifdef MEM_ARB_DEBUG_PORT_EN
                else if (g_req) begin
                    owner_d = OWN_G;
                    we_d    = 1'b0;
                    addr_d  = g_addr;
                    wdata_d = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
`endif
            end
            ISSUE: begin
                // An ack in the final timeout cycle still completes normally.
                if (mem_ack) begin
                    if (!we_q) rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign d_done    = (state_q == DONE) && (owner_q == OWN_D);
    assign f_done    = (state_q == DONE) && (owner_q == OWN_F);
`ifdef MEM_ARB_DEBUG_PORT_EN
    assign g_done    = (state_q == DONE) && (owner_q == OWN_G);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (TIMEOUT=4): vector table plus hand sequences, done pulses scored from a queue.
module tb_mem_port_arbiter;

    localparam logic [7:0] NOACK = 8'hFF;
    localparam int OWN_D = 0, OWN_F = 1, OWN_G = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [23:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done;
    logic        f_req = 1'b0;
    logic [23:0] f_addr = '0;
    logic        f_done;
    logic        g_done_w;
`ifdef MEM_ARB_DEBUG_PORT_EN
    logic        g_req = 1'b0;
    logic [23:0] g_addr = '0;
    logic        g_done;
    assign g_done_w = g_done;
`else
    assign g_done_w = 1'b0;
`endif
    logic [15:0] rdata;
    logic        err;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          owner;
        logic [15:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        is_d;
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [7:0]  delay;
        logic [15:0] mrd;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[7];

    mem_port_arbiter #(.TIMEOUT(4), .ERR_DATA(16'hFFFF)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
`ifdef MEM_ARB_DEBUG_PORT_EN
        .g_req(g_req), .g_addr(g_addr), .g_done(g_done),
`endif
        .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (d_done || f_done || g_done_w) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {29'd0, g_done_w, f_done, d_done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_owner", {29'd0, g_done_w, f_done, d_done}, 32'd1 << e.owner);
                    chk("done_rdata", {16'd0, rdata}, {16'd0, e.rdata});
                    chk("done_err", {31'd0, err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic push_exp(input int owner, input logic [15:0] rd, input logic e);
        exp_t x;
        x.owner = owner; x.rdata = rd; x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic wait_mem_req(input string name, input int lat);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 20);
        chk(name, n, lat);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(d_done || f_done || g_done_w) && n < 40) begin @(negedge clk); n++; end
        chk(name, {31'd0, (d_done || f_done || g_done_w)}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n, hi, exp_hi;
        @(negedge clk);
        if (v.is_d) begin d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
        else begin f_req = 1'b1; f_addr = v.addr; end
        push_exp(v.is_d ? OWN_D : OWN_F, v.exp_rdata, v.exp_err);
        wait_mem_req("grant_latency", 1);
        chk("mem_addr", {8'd0, mem_addr}, {8'd0, v.addr});
        chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
        if (v.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
        hi = 0; n = 0;
        while (!(d_done || f_done) && n < 40) begin
            if (mem_req) hi++;
            if (v.delay != NOACK && mem_req && hi == int'(v.delay) + 1) begin
                mem_ack = 1'b1; mem_rdata = v.mrd;
            end else mem_ack = 1'b0;
            @(negedge clk); n++;
        end
        mem_ack = 1'b0;
        exp_hi = (v.delay == NOACK) ? 4 : int'(v.delay) + 1;
        chk("mem_req_cycles", hi, exp_hi);
        d_req = 1'b0; f_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk(name, {mem_req, mem_we, d_done, f_done, g_done_w, err, 26'd0},
            32'd0);
        chk({name, "_fields"}, {8'd0, mem_addr} | {16'd0, mem_wdata} | {16'd0, rdata}, 32'd0);
    endtask

    initial begin
        int n, t_done;
        vecs[0] = '{1'b0, 1'b0, 24'h002400, 16'h0000, 8'd0, 16'h4A21, 16'h4A21, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 24'h000100, 16'h0000, 8'd2, 16'h1234, 16'h1234, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 24'h1F0010, 16'h00FF, 8'd0, 16'hBEEF, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 24'hFFFFFF, 16'h0000, 8'd3, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 24'h000000, 16'h0000, NOACK, 16'h0000, 16'hFFFF, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 24'h123456, 16'hA5A5, 8'd1, 16'h7777, 16'hFFFF, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 24'h800000, 16'h0000, 8'd0, 16'h8001, 16'h8001, 1'b0};

        repeat (3) @(negedge clk);
        chk_idle("reset_state");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_reset_idle");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Late ack after a timeout must be discarded.
        @(negedge clk);
        f_req = 1'b1; f_addr = 24'h000ABC;
        push_exp(OWN_F, 16'hFFFF, 1'b1);
        wait_mem_req("to_grant", 1);
        wait_done("to_done");
        f_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_outputs", {mem_req, d_done, f_done, err, 12'd0, rdata}, {4'b0001, 12'd0, 16'hFFFF});

        // Store beats fetch in the same cycle; fetch done 3 cycles after store done.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h1F0010; d_wdata = 16'h00FF;
        f_req = 1'b1; f_addr = 24'h003300;
        push_exp(OWN_D, 16'hFFFF, 1'b0);
        push_exp(OWN_F, 16'h5A5A, 1'b0);
        wait_mem_req("sbf_grant", 1);
        chk("sbf_store_first", {mem_we, 7'd0, mem_addr}, {1'b1, 7'd0, 24'h1F0010});
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("sbf_d_done", {31'd0, d_done}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        t_done = 0;
        n = 0;
        while (!f_done && n < 20) begin
            if (mem_req) begin mem_ack = 1'b1; mem_rdata = 16'h5A5A; end else mem_ack = 1'b0;
            @(negedge clk); n++;
        end
        mem_ack = 1'b0;
        chk("sbf_f_done_gap", n, 3);
        f_req = 1'b0;

        // Back-to-back hold: f_req held across f_done re-grants.
        @(negedge clk);
        f_req = 1'b1; f_addr = 24'h000444;
        push_exp(OWN_F, 16'h0101, 1'b0);
        push_exp(OWN_F, 16'h0202, 1'b0);
        wait_mem_req("b2b_grant", 1);
        mem_ack = 1'b1; mem_rdata = 16'h0101;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_first_done", {31'd0, f_done}, 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 10);
        chk("b2b_regrant_gap", n, 2);
        mem_ack = 1'b1; mem_rdata = 16'h0202;
        @(negedge clk);
        mem_ack = 1'b0;
        f_req = 1'b0;
        chk("b2b_second_done", {31'd0, f_done}, 32'd1);

`ifdef MEM_ARB_DEBUG_PORT_EN
        @(negedge clk);
        g_req = 1'b1; g_addr = 24'h00D000;
        f_req = 1'b1; f_addr = 24'h00F000;
        push_exp(OWN_F, 16'hF00D, 1'b0);
        push_exp(OWN_G, 16'hD00D, 1'b0);
        wait_mem_req("dbg_fetch_first", 1);
        chk("dbg_fetch_addr", {8'd0, mem_addr}, {8'd0, 24'h00F000});
        mem_ack = 1'b1; mem_rdata = 16'hF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        f_req = 1'b0;
        wait_mem_req("dbg_grant", 2);
        chk("dbg_addr", {8'd0, mem_addr}, {8'd0, 24'h00D000});
        mem_ack = 1'b1; mem_rdata = 16'hD00D;
        @(negedge clk);
        mem_ack = 1'b0;
        g_req = 1'b0;
        chk("dbg_done", {31'd0, g_done}, 32'd1);
`endif

        // Asynchronous reset in ISSUE drops mem_req at once, no done pulse.
        @(negedge clk);
        f_req = 1'b1; f_addr = 24'h00BEEF;
        wait_mem_req("rst_grant", 1);
        #2 reset = 1'b0;
        #1 chk("rst_mem_req_async", {31'd0, mem_req}, 32'd0);
        f_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("rst_idle");
        repeat (3) @(negedge clk);
        chk("rst_no_done", {29'd0, g_done_w, f_done, d_done}, 32'd0);

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
